key_debounce_sync: RTL and testbench
====================================

// Module: key_debounce_sync
// PURPOSE
//   Conditions the raw push-button inputs (active-low) before they reach the
//   keys PIO of the nios_system. Per channel: 2-FF synchroniser, stable-time
//   debounce counter, debounced level output, one-cycle press/release pulses
//   and sticky press-event flags cleared by software.
//   keys_export feeds the nios_system keys_export input directly.
// PARAMETERS
//   NUM_KEYS         4        number of independent key channels
//   DEBOUNCE_CYCLES  500000   clocks of stable input before accepting a new level (10 ms @ 50 MHz); legal range >= 2
//   CNT_W            $clog2(DEBOUNCE_CYCLES)  counter width, derived; not overridden
// PORTS
//   clk_clk        in   1         system clock (50 MHz); all logic on its rising edge
//   reset_reset_n  in   1         asynchronous, active-low reset
//   keys_raw       in   NUM_KEYS  raw board keys, active-low (0 = pressed), asynchronous to clk_clk
//   event_clear    in   NUM_KEYS  write-1-to-clear for key_event, one bit per channel
//   keys_export    out  NUM_KEYS  debounced level, active-low; connects to nios_system keys_export
//   press_pulse    out  NUM_KEYS  1-cycle pulse on accepted 1->0 transition of keys_export
//   release_pulse  out  NUM_KEYS  1-cycle pulse on accepted 0->1 transition of keys_export
//   key_event      out  NUM_KEYS  sticky flag; set by press_pulse, cleared by event_clear
// BEHAVIOUR
//   Reset (async assert, sync release):
//   - sync FFs = all 1s; keys_export = all 1s (released)
//   - press_pulse = release_pulse = key_event = 0; all counters = 0
//   Synchroniser: sync1 <= keys_raw; sync2 <= sync1. Only sync2 is used by the debounce logic.
//   Per channel, each rising edge:
//   - sync2 == keys_export: counter <= 0, no pulse.
//   - sync2 != keys_export, counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
//   - sync2 != keys_export, counter == DEBOUNCE_CYCLES-1:
//       keys_export <= sync2, counter <= 0,
//       press_pulse <= 1 if new level is 0, else release_pulse <= 1.
//   - Any bounce back to the accepted level before acceptance restarts the count from 0.
//   - Pulses are registered and high for exactly one cycle.
//   - press_pulse and release_pulse are never high together on one channel.
//   Latency:
//   - Edge 1 = first edge that samples the new raw level into sync1.
//   - keys_export changes at edge DEBOUNCE_CYCLES+2; the pulse is high in the cycle after that edge.
//   - The raw level must hold for >= DEBOUNCE_CYCLES consecutive sync2 samples.
//   key_event:
//   - Set on the edge where press_pulse goes high.
//   - Cleared on any edge where event_clear bit = 1 and no press is accepted on that edge.
//   - Simultaneous set and clear on one channel: set wins, flag stays 1.
//   - event_clear on a flag already 0 has no effect.
//   Channels are fully independent. Simultaneous transitions on several keys each produce their own pulse on the same cycle.
//   Counter never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.
//   Reset mid-count: counter discarded, outputs return to reset values at once.
//   After reset release, a key held down is accepted as a normal press after the full latency.
// TESTING (bench with DEBOUNCE_CYCLES=4)
//   1. Reset, keys_raw=4'hF held 20 cycles -> keys_export=4'hF; no pulses; key_event=0.
//   2. keys_raw[0] 1->0 and held -> keys_export[0]=0 at edge 6 (edge 1 samples the change); press_pulse[0] high 1 cycle; key_event[0]=1.
//   3. keys_raw[1] toggles 0,1,0,1 every 2 cycles then held 0 -> no pulse during bouncing; one press_pulse[1] exactly 6 edges after the final 1->0.
//   4. key_event[2]=1, event_clear[2]=1 on the same edge as a new press_pulse[2] -> key_event[2] stays 1; clear on the next edge -> 0.
//   5. keys_raw[3:0] all released 0->1 together -> release_pulse=4'hF in a single cycle; key_event unchanged.
//   6. reset_reset_n asserted with counter=2 on key 0 -> all outputs at reset values immediately; after release, key held 0 -> press after full 6-edge latency.

Source files
------------

// File: rtl/key_debounce_sync_if.sv
// Key-conditioning bus: raw keys and event clears in, debounced level,
// press/release pulses and sticky event flags out.
interface key_debounce_sync_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] keys_raw;
  logic [NUM_KEYS-1:0] event_clear;
  logic [NUM_KEYS-1:0] keys_export;
  logic [NUM_KEYS-1:0] press_pulse;
  logic [NUM_KEYS-1:0] release_pulse;
  logic [NUM_KEYS-1:0] key_event;

  modport master (
    output keys_raw, event_clear,
    input  keys_export, press_pulse, release_pulse, key_event
  );

  modport slave (
    input  keys_raw, event_clear,
    output keys_export, press_pulse, release_pulse, key_event
  );
endinterface

// File: rtl/key_debounce_sync.sv
// Active-low push-button conditioner: 2-FF synchroniser, stable-time debounce,
// debounced level, one-cycle press/release pulses and sticky press flags.
module key_debounce_sync #(
  parameter  int NUM_KEYS        = 4,
  parameter  int DEBOUNCE_CYCLES = 500000,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  key_debounce_sync_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;

  // Sync FFs reset to released (1) so no phantom press follows reset.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= bus.keys_raw;
      r_sync2 <= r_sync1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_ch
      logic [CNT_W-1:0] r_cnt;
      logic             r_level;
      logic             r_press;
      logic             r_release;
      logic             r_event;
      logic             w_differ;
      logic             w_accept;
      logic             w_press_accept;

      assign w_differ       = r_sync2[gi] ^ r_level;
      assign w_accept       = w_differ && (r_cnt == CNT_MAX);
      assign w_press_accept = w_accept && !r_sync2[gi];

      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
          r_cnt     <= '0;
          r_level   <= 1'b1;
          r_press   <= 1'b0;
          r_release <= 1'b0;
          r_event   <= 1'b0;
        end else begin
          r_press   <= 1'b0;
          r_release <= 1'b0;
          if (!w_differ) begin
            r_cnt <= '0;
          end else if (w_accept) begin
            r_level   <= r_sync2[gi];
            r_cnt     <= '0;
            r_press   <= !r_sync2[gi];
            r_release <= r_sync2[gi];
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
          // A press accepted on the same edge as a clear keeps the flag set.
          if (w_press_accept) begin
            r_event <= 1'b1;
          end else if (bus.event_clear[gi]) begin
            r_event <= 1'b0;
          end
        end
      end

      assign bus.keys_export[gi]   = r_level;
      assign bus.press_pulse[gi]   = r_press;
      assign bus.release_pulse[gi] = r_release;
      assign bus.key_event[gi]     = r_event;
    end
  endgenerate

endmodule

// File: tb/tb_key_debounce_sync.sv
// Directed bench for key_debounce_sync (DEBOUNCE_CYCLES=4): stimulus queues
// expected snapshots keyed by edge number; a monitor compares them.
module tb_key_debounce_sync;

  logic clk_clk;
  logic reset_reset_n;
  int   edge_cnt;
  int   total;
  int   bad;

  typedef struct {
    int         cyc;
    logic [3:0] exp_level;
    logic [3:0] exp_press;
    logic [3:0] exp_release;
    logic [3:0] exp_event;
  } snap_t;

  snap_t sb_q[$];

  key_debounce_sync_if #(.NUM_KEYS(4)) bus ();

  key_debounce_sync #(
    .NUM_KEYS       (4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .bus          (bus)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  initial edge_cnt = 0;
  always @(posedge clk_clk) edge_cnt <= edge_cnt + 1;

  task automatic check4(input string name, input int cyc, input logic [3:0] act,
                        input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at edge %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  // Monitor: compares due snapshots; any pulse without a due snapshot is an error.
  always @(negedge clk_clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc < edge_cnt) begin
      total++;
      bad++;
      $display("FAIL missed_snapshot for edge %0d (now %0d)", sb_q[0].cyc, edge_cnt);
      void'(sb_q.pop_front());
    end
    if (sb_q.size() > 0 && sb_q[0].cyc == edge_cnt) begin
      snap_t s;
      s = sb_q.pop_front();
      check4("keys_export",   edge_cnt, bus.keys_export,   s.exp_level);
      check4("press_pulse",   edge_cnt, bus.press_pulse,   s.exp_press);
      check4("release_pulse", edge_cnt, bus.release_pulse, s.exp_release);
      check4("key_event",     edge_cnt, bus.key_event,     s.exp_event);
      $display("edge %0d: export=%h press=%h release=%h event=%h", edge_cnt,
               bus.keys_export, bus.press_pulse, bus.release_pulse, bus.key_event);
    end else if (reset_reset_n) begin
      check4("no_unexpected_pulse", edge_cnt, bus.press_pulse | bus.release_pulse, 4'h0);
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk_clk);
    #1;
  endtask

  task automatic push_abs(input int cyc, input logic [3:0] lv, input logic [3:0] pr,
                          input logic [3:0] rl, input logic [3:0] ev);
    snap_t s;
    s.cyc = cyc; s.exp_level = lv; s.exp_press = pr; s.exp_release = rl; s.exp_event = ev;
    sb_q.push_back(s);
  endtask

  initial begin
    int k;
    total = 0;
    bad   = 0;
    reset_reset_n   = 1'b0;
    bus.keys_raw    = 4'hF;
    bus.event_clear = 4'h0;

    // 1: reset state and idle keys
    wait_neg(3);
    reset_reset_n = 1'b1;
    k = edge_cnt;
    push_abs(k + 1,  4'hF, 4'h0, 4'h0, 4'h0);
    push_abs(k + 20, 4'hF, 4'h0, 4'h0, 4'h0);
    wait_neg(22);

    // 2: key 0 press, 6-edge latency, single-cycle pulse
    k = edge_cnt;
    bus.keys_raw = 4'hE;
    push_abs(k + 6, 4'hE, 4'h1, 4'h0, 4'h1);
    push_abs(k + 7, 4'hE, 4'h0, 4'h0, 4'h1);
    wait_neg(10);

    // 3: key 1 bounces, then settles low
    bus.keys_raw = 4'hC; wait_neg(2);
    bus.keys_raw = 4'hE; wait_neg(2);
    bus.keys_raw = 4'hC; wait_neg(2);
    bus.keys_raw = 4'hE; wait_neg(2);
    k = edge_cnt;
    bus.keys_raw = 4'hC;
    push_abs(k + 6, 4'hC, 4'h2, 4'h0, 4'h3);
    push_abs(k + 7, 4'hC, 4'h0, 4'h0, 4'h3);
    wait_neg(10);

    // 4: key 2 press, release, re-press with clear colliding with the press
    k = edge_cnt;
    bus.keys_raw = 4'h8;
    push_abs(k + 6, 4'h8, 4'h4, 4'h0, 4'h7);
    wait_neg(10);
    k = edge_cnt;
    bus.keys_raw = 4'hC;
    push_abs(k + 6, 4'hC, 4'h0, 4'h4, 4'h7);
    wait_neg(10);
    k = edge_cnt;
    bus.keys_raw = 4'h8;
    push_abs(k + 6, 4'h8, 4'h4, 4'h0, 4'h7);
    push_abs(k + 7, 4'h8, 4'h0, 4'h0, 4'h3);
    wait_neg(5);
    bus.event_clear = 4'hC;
    wait_neg(2);
    bus.event_clear = 4'h0;
    wait_neg(5);

    // 5: press key 3, then release all four together
    k = edge_cnt;
    bus.keys_raw = 4'h0;
    push_abs(k + 6, 4'h0, 4'h8, 4'h0, 4'hB);
    wait_neg(10);
    k = edge_cnt;
    bus.keys_raw = 4'hF;
    push_abs(k + 6, 4'hF, 4'h0, 4'hF, 4'hB);
    push_abs(k + 7, 4'hF, 4'h0, 4'h0, 4'hB);
    wait_neg(10);

    // 6: reset pulse (no clock edge inside it) while key 0 counts
    k = edge_cnt;
    bus.keys_raw = 4'hE;
    push_abs(k + 5,  4'hF, 4'h0, 4'h0, 4'h0);
    push_abs(k + 10, 4'hE, 4'h1, 4'h0, 4'h1);
    push_abs(k + 11, 4'hE, 4'h0, 4'h0, 4'h1);
    wait_neg(4);
    reset_reset_n = 1'b0;
    #2;
    reset_reset_n = 1'b1;
    wait_neg(12);

    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
